// File: rtl/stdp_pulse_ctrl_if.sv
// Bundle between the STDP learning controller and its environment: window
// and spike inputs, the weight register's thermometer value, and the
// inc/dec pulses plus the decision code coming back.
interface stdp_pulse_ctrl_if #(
  parameter int INPUT_SIZE = 8
);
  logic                  gamma;
  logic                  learn_en;
  logic                  in_spike;
  logic                  out_spike;
  logic [INPUT_SIZE-1:0] weight;
  logic                  inc;
  logic                  dec;
  logic [2:0]            last_case;

  // Environment side: drives windows, spikes and weight, observes pulses.
  modport master (
    output gamma, learn_en, in_spike, out_spike, weight,
    input  inc, dec, last_case
  );

  // Controller side.
  modport slave (
    input  gamma, learn_en, in_spike, out_spike, weight,
    output inc, dec, last_case
  );
endinterface

// File: rtl/stdp_pulse_ctrl.sv
// STDP-style learning controller. Each gamma-delimited window records the
// first pre- and postsynaptic spike times. At the next gamma the closing
// window is classified and at most one saturating inc/dec pulse is issued
// to the thermometer weight register, one cycle after gamma.
module stdp_pulse_ctrl #(
  parameter int INPUT_SIZE = 8,
  parameter int TIME_BITS  = 4
) (
  input logic              clk,
  input logic              rst,
  stdp_pulse_ctrl_if.slave bus
);

  typedef enum logic {
    S_WAIT   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  typedef enum logic [2:0] {
    C_NONE    = 3'd0,
    C_CAPTURE = 3'd1,
    C_DEPRESS = 3'd2,
    C_SEARCH  = 3'd3,
    C_BACKOFF = 3'd4
  } case_t;

  state_t               r_state;
  logic [TIME_BITS-1:0] r_cnt;
  logic                 r_in_seen;
  logic                 r_out_seen;
  logic [TIME_BITS-1:0] r_t_in;
  logic [TIME_BITS-1:0] r_t_out;
  logic                 r_inc;
  logic                 r_dec;
  case_t                r_last_case;

  case_t w_case;
  logic  w_req_inc;
  logic  w_req_dec;
  logic  w_fire_inc;
  logic  w_fire_dec;

  // Classify the window that is closing, from its captured flags and times.
  always_comb begin
    w_case = C_NONE;
    if (r_in_seen && r_out_seen) begin
      if (r_t_in <= r_t_out) w_case = C_CAPTURE;
      else                   w_case = C_DEPRESS;
    end else if (r_in_seen) begin
      w_case = C_SEARCH;
    end else if (r_out_seen) begin
      w_case = C_BACKOFF;
    end
  end

  assign w_req_inc  = (w_case == C_CAPTURE) || (w_case == C_SEARCH);
  assign w_req_dec  = (w_case == C_DEPRESS) || (w_case == C_BACKOFF);
  // Full register blocks inc, empty register blocks dec.
  assign w_fire_inc = bus.learn_en && w_req_inc && !bus.weight[INPUT_SIZE-1];
  assign w_fire_dec = bus.learn_en && w_req_dec &&  bus.weight[0];

  // Window FSM, spike capture, and registered single-cycle pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_WAIT;
      r_cnt       <= '0;
      r_in_seen   <= 1'b0;
      r_out_seen  <= 1'b0;
      r_t_in      <= '0;
      r_t_out     <= '0;
      r_inc       <= 1'b0;
      r_dec       <= 1'b0;
      r_last_case <= C_NONE;
    end else begin
      r_inc <= 1'b0;
      r_dec <= 1'b0;
      if (bus.gamma) begin
        // Only an ACTIVE window has anything to evaluate; the first gamma
        // out of WAIT just opens a window.
        if (r_state == S_ACTIVE) begin
          r_last_case <= w_case;
          r_inc       <= w_fire_inc;
          r_dec       <= w_fire_dec;
        end
        r_state    <= S_ACTIVE;
        // The counter holds the time of the cycle it is read in; gamma is
        // time 0, so the first cycle after it reads 1.
        r_cnt      <= TIME_BITS'(1);
        r_in_seen  <= bus.in_spike;
        r_out_seen <= bus.out_spike;
        r_t_in     <= '0;
        r_t_out    <= '0;
      end else if (r_state == S_ACTIVE) begin
        if (r_cnt != '1) r_cnt <= r_cnt + TIME_BITS'(1);
        if (bus.in_spike && !r_in_seen) begin
          r_in_seen <= 1'b1;
          r_t_in    <= r_cnt;
        end
        if (bus.out_spike && !r_out_seen) begin
          r_out_seen <= 1'b1;
          r_t_out    <= r_cnt;
        end
      end
    end
  end

  assign bus.inc       = r_inc;
  assign bus.dec       = r_dec;
  assign bus.last_case = r_last_case;

endmodule

// File: tb/tb_stdp_pulse_ctrl.sv
// Directed bench for stdp_pulse_ctrl. Each gamma pushes the hand-computed
// response for the window it closes; a negedge monitor pops it in the cycle
// after gamma and otherwise expects idle pulses and an unchanged last_case.
module tb_stdp_pulse_ctrl;

  typedef struct packed {
    logic       inc;
    logic       dec;
    logic [2:0] lc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  exp_t q[$];
  logic g_prev;
  logic rst_prev;
  logic [2:0] exp_last;

  stdp_pulse_ctrl_if #(.INPUT_SIZE(8)) sif ();

  stdp_pulse_ctrl #(.INPUT_SIZE(8), .TIME_BITS(4)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Remember what the DUT saw at each rising edge.
  always @(posedge clk) begin
    g_prev   <= sif.gamma && rst_n;
    rst_prev <= !rst_n;
  end

  // Monitor: pop on the cycle after gamma, otherwise expect idle outputs.
  initial begin
    exp_last = 3'd0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (rst_prev) exp_last = 3'd0;
      total++;
      if (g_prev) begin
        if (q.size() == 0) begin
          bad++;
          $display("FAIL pulse_nomodel: got inc=%b dec=%b case=%0d, no expectation queued",
                   sif.inc, sif.dec, sif.last_case);
        end else begin
          exp_t e;
          e = q.pop_front();
          if ({sif.inc, sif.dec, sif.last_case} !== e) begin
            bad++;
            $display("FAIL pulse @%0t: got inc=%b dec=%b case=%0d, want inc=%b dec=%b case=%0d",
                     $time, sif.inc, sif.dec, sif.last_case, e.inc, e.dec, e.lc);
          end
          exp_last = e.lc;
        end
      end else if ({sif.inc, sif.dec, sif.last_case} !== {2'b00, exp_last}) begin
        bad++;
        $display("FAIL idle @%0t: got inc=%b dec=%b case=%0d, want inc=0 dec=0 case=%0d",
                 $time, sif.inc, sif.dec, sif.last_case, exp_last);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One gamma cycle; queues the response expected for the closing window.
  task automatic gam(input logic [7:0] w, input logic le, input logic gin,
                     input logic gout, input logic ei, input logic ed,
                     input logic [2:0] ec);
    exp_t e;
    e.inc = ei;
    e.dec = ed;
    e.lc  = ec;
    q.push_back(e);
    sif.gamma     = 1'b1;
    sif.weight    = w;
    sif.learn_en  = le;
    sif.in_spike  = gin;
    sif.out_spike = gout;
    tick();
    sif.gamma     = 1'b0;
    sif.in_spike  = 1'b0;
    sif.out_spike = 1'b0;
  endtask

  // Window times 1..len-1 after a gamma; a time of -1 means no spike.
  task automatic win(input int len, input int tin, input int tout, input int tin2);
    for (int c = 1; c < len; c++) begin
      sif.in_spike  = (c == tin) || (c == tin2);
      sif.out_spike = (c == tout);
      tick();
    end
    sif.in_spike  = 1'b0;
    sif.out_spike = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    sif.gamma     = 1'b0;
    sif.learn_en  = 1'b1;
    sif.in_spike  = 1'b0;
    sif.out_spike = 1'b0;
    sif.weight    = 8'h00;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // First gamma opens a window only; then in@2 out@5 -> CAPTURE, inc.
    gam(8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    win(10, 2, 5, -1);
    gam(8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1);
    // in@6 out@3 -> DEPRESS, dec.
    win(10, 6, 3, -1);
    gam(8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2);
    // in only, full weight -> SEARCH, inc suppressed.
    win(10, 4, -1, -1);
    gam(8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3);
    // out only, empty weight -> BACKOFF, dec suppressed.
    win(10, -1, 5, -1);
    gam(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4);
    // Tie at t=4 -> CAPTURE, inc.
    win(10, 4, 4, -1);
    gam(8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1);
    // in_spike on the gamma cycle belongs to the new window at t=0.
    win(10, -1, 5, -1);
    gam(8'h0F, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd4);
    win(10, -1, 3, -1);
    gam(8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1);
    // Second in_spike at t=7 ignored: in@1 out@4 -> CAPTURE.
    win(10, 1, 4, 7);
    gam(8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1);
    // learn_en low: DEPRESS recorded, no pulse.
    win(10, 6, 3, -1);
    gam(8'h07, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2);
    // Counter saturates: in@20 out@16 both read 15 -> tie -> inc.
    win(21, 20, 16, -1);
    gam(8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1);
    // Back-to-back gammas: empty, in@0, out@0 one-cycle windows.
    gam(8'h07, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    gam(8'h07, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd3);
    gam(8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4);
    // Reset mid-window with both spikes captured discards the window.
    win(8, 2, 5, -1);
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    gam(8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    win(10, 2, 5, -1);
    gam(8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1);
    repeat (4) tick();

    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d expectations left, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stdp_pulse_ctrl.md
Name: stdp_pulse_ctrl

Overview:
- Upstream learning controller for the thermometer-coded weight register (ffsr_pulse).
- Per compute window (gamma cycle), records the first input spike time and first output spike time, then applies an STDP-style rule.
- At the window boundary it emits at most one single-cycle inc or dec pulse, which drives the register's inc/dec pins directly.
- Saturation is enforced here, using the register's current thermometer value.

Parameters:
- INPUT_SIZE, 8, weight width in bits; must match the attached ffsr_pulse (>1).
- TIME_BITS, 4, width of the in-window cycle counter and captured spike times.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset.
- gamma  input  1  single-cycle pulse marking the first cycle of a new window.
- learn_en  input  1  when low, decisions are computed but no inc/dec is emitted.
- in_spike  input  1  presynaptic spike, single-cycle pulse.
- out_spike  input  1  postsynaptic spike, single-cycle pulse.
- weight  input  INPUT_SIZE  current thermometer value from the weight register.
- inc  output  1  single-cycle increment pulse to the weight register.
- dec  output  1  single-cycle decrement pulse to the weight register.
- last_case  output  3  code of the most recent decision (debug/verification).

Behaviour:
- Reset (rst=0 at an edge):
  - inc=0, dec=0, last_case=0 (NONE).
  - Counter=0, spike flags and captured times cleared, FSM to WAIT.
  - Reset during an active window discards that window; no pulse results.
- FSM states:
  - WAIT: ignore spikes, outputs idle. Go to ACTIVE on gamma=1.
  - ACTIVE: track the window. On each gamma, evaluate the closing window and start a new one.
- Window timing:
  - The gamma cycle is time 0.
  - Counter increments by 1 each subsequent cycle and saturates at 2^TIME_BITS-1 (no wrap).
  - A spike arriving in the gamma cycle belongs to the new window with time 0.
- Capture:
  - Only the first in_spike and first out_spike per window are recorded (flag + time).
  - Later spikes in the same window are ignored.
  - Spikes in WAIT are ignored.
- Decision, evaluated in the gamma cycle from the closing window's state:
  - Both spikes, t_in <= t_out: CAPTURE (1), request inc. A tie counts as CAPTURE.
  - Both spikes, t_in > t_out: DEPRESS (2), request dec.
  - in_spike only: SEARCH (3), request inc.
  - out_spike only: BACKOFF (4), request dec.
  - Neither: NONE (0), no request.
- Saturation, using weight sampled in the gamma cycle:
  - inc suppressed if weight[INPUT_SIZE-1]=1 (full).
  - dec suppressed if weight[0]=0 (empty).
  - last_case still records the rule outcome when a pulse is suppressed.
- Output timing:
  - inc/dec are registered and asserted exactly in the cycle after gamma (latency 1), for exactly one cycle.
  - inc and dec are never both 1.
  - learn_en is sampled in the gamma cycle; if 0, both pulses are suppressed.
  - last_case updates in the same cycle the pulse would appear.
- First gamma after reset (transition from WAIT): no prior window exists, so no pulse is emitted and last_case stays NONE.
- Back-to-back gammas (consecutive cycles): each closes a one-cycle window. Pulses may therefore appear on consecutive cycles, each pulse reflecting its own window.
- gamma and spikes are assumed to be synchronous to clk. Multi-cycle-high spike inputs are treated as one spike (first cycle captured).

Test Plan:
- Reset, gamma@0, in_spike@t=2, out_spike@t=5, gamma@10, weight=8'b00000111, learn_en=1 -> inc=1 only at cycle 11, last_case=1; the register then reads 8'b00001111.
- Same but in@t=6, out@t=3, weight=8'b00000111 -> dec=1 at cycle 11, last_case=2.
- in_spike only, weight=8'hFF -> no inc (saturated), last_case=3.
- out_spike only, weight=8'h00 -> no dec, last_case=4.
- Tie: in and out both at t=4 -> inc, last_case=1.
- Spike in the gamma cycle counts as t=0 of the new window.
- Second in_spike at t=7 after first at t=1 is ignored.
- learn_en=0 -> no pulses, last_case still updated.
- Reset asserted mid-window with both spikes captured, then released, then gamma -> no pulse, last_case=0.
- First gamma after reset -> no pulse.
- Counter saturation: TIME_BITS=4, in@t=20, out@t=16 -> both saturate to 15, tie -> inc.
